// File: rtl/sram_arbiter_ctrl.sv
// Two-port arbiter and setup/strobe/hold sequencer for one asynchronous SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_arbiter_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  grant,
    output logic [ADDR_WIDTH-1:0] sramAddr,
    inout  wire  [DATA_WIDTH-1:0] sramData,
    output logic                  notCS,
    output logic                  notOE,
    output logic                  notWE
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    typedef struct packed {
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
    } xfer_t;

    localparam logic [3:0] CNT_LAST = 4'(STROBE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    xfer_t                 cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  grant_q, grant_d;
    logic                  cs_n_q, cs_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  drive_q, drive_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  pick1;
    logic                  win_we;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;
    // rr_q names the preferred port when both request
    assign pick1 = req1 & (~req0 | rr_q);
`else
    assign pick1 = req1 & ~req0;
`endif

    assign win_we = pick1 ? we1 : we0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        addr_d   = addr_q;
        grant_d  = grant_q;
        cs_n_d   = cs_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        drive_d  = drive_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d     = SETUP;
                    grant_d     = pick1;
                    cur_d.we    = win_we;
                    cur_d.wdata = pick1 ? wdata1 : wdata0;
                    addr_d      = pick1 ? addr1 : addr0;
                    cs_n_d      = 1'b0;
                    oe_n_d      = win_we;
                    drive_d     = win_we;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    rr_d        = ~pick1;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LAST;
                we_n_d  = ~cur_q.we;
                oe_n_d  = cur_q.we;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    if (!cur_q.we) begin
                        if (grant_q) rdata1_d = sramData;
                        else         rdata0_d = sramData;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                // Data stays driven through HOLD; released here for one turnaround cycle
                state_d = IDLE;
                cs_n_d  = 1'b1;
                drive_d = 1'b0;
                grant_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            cur_q    <= '0;
            addr_q   <= '0;
            grant_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            drive_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            addr_q   <= addr_d;
            grant_q  <= grant_d;
            cs_n_q   <= cs_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            drive_q  <= drive_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign sramData = drive_q ? cur_q.wdata : {DATA_WIDTH{1'bz}};
    assign sramAddr = addr_q;
    assign notCS    = cs_n_q;
    assign notOE    = oe_n_q;
    assign notWE    = we_n_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);

endmodule
